// File: rtl/data_mem_access_pkg.sv
// Shared types and constants for the data memory access unit.
package data_mem_access_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_REQ,
        DMA_WAIT,
        DMA_WB,
        DMA_ERR
    } dma_state_e;

    localparam int DMA_TIMEOUT_CYCLES = 16;
    localparam int DMA_CNT_W          = $clog2(DMA_TIMEOUT_CYCLES);

endpackage

// File: rtl/tristate_driver.sv
// Drives a bus when enabled, otherwise releases it to high impedance.
module tristate_driver #(
    parameter int DATA_W = 8
) (
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    output tri   [DATA_W-1:0] data_out
);

    assign data_out = en ? data_in : {DATA_W{1'bz}};

endmodule

// File: rtl/data_mem_access_unit.sv
// Load/store sequencer: captures address/data, runs req/gnt/rvalid with data
// memory and writes load results back onto the accumulator bus.
module data_mem_access_unit
    import data_mem_access_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int D_ADDR_WIDTH   = 12,
    parameter int TIMEOUT_CYCLES = DMA_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_start,
    input  logic                    store_start,
    input  logic [D_ADDR_WIDTH-1:0] dmar,
    input  logic [DATA_W-1:0]       acc_out,
    output tri   [DATA_W-1:0]       acc_bus,
    output logic                    acc_write_enable,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [D_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dma_state_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [D_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       rdata_q;
    logic                    we_q;
    logic                    req_q;
    logic                    acc_we_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;

    // NOTE: all state below is sequential, so every assignment is non-blocking;
    // pulse outputs default low each cycle and are raised only on the edge
    // that enters the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= DMA_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            req_q    <= 1'b0;
            acc_we_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            acc_we_q <= 1'b0;
            case (state_q)
                DMA_IDLE: begin
                    if (load_start && store_start) begin
                        state_q <= DMA_ERR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (load_start || store_start) begin
                        state_q <= DMA_REQ;
                        addr_q  <= dmar;
                        if (store_start) wdata_q <= acc_out;
                        we_q    <= store_start;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                DMA_REQ: begin
                    // A grant on the final counted cycle still wins over the timeout.
                    if (mem_gnt) begin
                        req_q <= 1'b0;
                        if (we_q) begin
                            state_q <= DMA_IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (mem_rvalid) begin
                            state_q  <= DMA_WB;
                            rdata_q  <= mem_rdata;
                            acc_we_q <= 1'b1;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= DMA_WAIT;
                            cnt_q   <= '0;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DMA_ERR;
                        req_q   <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DMA_WAIT: begin
                    if (mem_rvalid) begin
                        state_q  <= DMA_WB;
                        rdata_q  <= mem_rdata;
                        acc_we_q <= 1'b1;
                        done_q   <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DMA_ERR;
                        error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DMA_WB, DMA_ERR: begin
                    state_q <= DMA_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= DMA_IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    tristate_driver #(
        .DATA_W (DATA_W)
    ) u_acc_drv (
        .en       (state_q == DMA_WB),
        .data_in  (rdata_q),
        .data_out (acc_bus)
    );

    assign acc_write_enable = acc_we_q;
    assign mem_req          = req_q;
    assign mem_we           = we_q;
    assign mem_addr         = addr_q;
    assign mem_wdata        = wdata_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: each transaction is turned into an expected
// cycle timeline from the handshake rules and compared cycle by cycle.
module tb_data_mem_access_unit;

    localparam int T       = 16;
    localparam int K_LOAD  = 0;
    localparam int K_STORE = 1;
    localparam int K_BOTH  = 2;

    logic        clk;
    logic        reset_n;
    logic        load_start;
    logic        store_start;
    logic [11:0] dmar;
    logic [7:0]  acc_out;
    wire  [7:0]  acc_bus;
    logic        acc_write_enable;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic        error;

    int checks;
    int failures;

    // Values the captured address/data registers should currently hold.
    logic [11:0] m_addr;
    logic [7:0]  m_wdata;

    data_mem_access_unit #(
        .DATA_W         (8),
        .D_ADDR_WIDTH   (12),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_start       (load_start),
        .store_start      (store_start),
        .dmar             (dmar),
        .acc_out          (acc_out),
        .acc_bus          (acc_bus),
        .acc_write_enable (acc_write_enable),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        load_start  = 1'b0;
        store_start = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 8'($urandom);
        dmar        = 12'($urandom);
        acc_out     = 8'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        #12;
        checks++;
        if ({mem_req, mem_we, acc_write_enable, busy, done, error} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {mem_req, mem_we, acc_write_enable, busy, done, error});
        end
        checks++;
        if (mem_addr !== 12'h000 || mem_wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_regs addr=%h wdata=%h exp=000/00", mem_addr, mem_wdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_addr  = 12'h000;
        m_wdata = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    // g: REQ cycles before gnt (outside 0..T-1 means never granted).
    // r: cycles from gnt to rvalid (0 = same cycle, outside 0..T means never).
    task automatic run_txn(input string name, input int kind, input logic [11:0] addr,
                           input logic [7:0] wdata, input int g, input int r,
                           input logic [7:0] rdata, input bit stray_start,
                           input bit stray_rv);
        int req_first, req_last, done_c, err_c, wb_c, idle_c, cg;
        logic [11:0] exp_addr;
        logic [7:0]  exp_wdata;
        req_first = -1; req_last = -2; done_c = -1; err_c = -1; wb_c = -1;
        cg = 1 + g;
        if (kind == K_BOTH) begin
            err_c = 1; idle_c = 2;
        end else if (g < 0 || g > T - 1) begin
            req_first = 1; req_last = T; err_c = T + 1; idle_c = T + 2;
        end else begin
            req_first = 1; req_last = cg;
            if (kind == K_STORE) begin
                done_c = cg + 1; idle_c = cg + 1;
            end else if (r >= 0 && r <= T) begin
                wb_c = cg + r + 1; done_c = wb_c; idle_c = wb_c + 1;
            end else begin
                err_c = cg + T + 1; idle_c = cg + T + 2;
            end
        end
        exp_addr  = (kind == K_BOTH)  ? m_addr : addr;
        exp_wdata = (kind == K_STORE) ? wdata  : m_wdata;

        for (int k = 0; k <= idle_c; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (mem_req !== (k >= req_first && k <= req_last)) begin
                    failures++;
                    $display("FAIL %s k=%0d mem_req got=%b exp=%b", name, k, mem_req,
                             (k >= req_first && k <= req_last));
                end
                checks++;
                if (busy !== (k < idle_c)) begin
                    failures++;
                    $display("FAIL %s k=%0d busy got=%b exp=%b", name, k, busy, (k < idle_c));
                end
                checks++;
                if (done !== (k == done_c) || error !== (k == err_c)) begin
                    failures++;
                    $display("FAIL %s k=%0d done/error got=%b/%b exp=%b/%b", name, k,
                             done, error, (k == done_c), (k == err_c));
                end
                checks++;
                if (acc_write_enable !== (k == wb_c)) begin
                    failures++;
                    $display("FAIL %s k=%0d acc_write_enable got=%b exp=%b", name, k,
                             acc_write_enable, (k == wb_c));
                end
                checks++;
                if (mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
                    failures++;
                    $display("FAIL %s k=%0d addr/wdata got=%h/%h exp=%h/%h", name, k,
                             mem_addr, mem_wdata, exp_addr, exp_wdata);
                end
                if (k >= req_first && k <= req_last) begin
                    checks++;
                    if (mem_we !== (kind == K_STORE)) begin
                        failures++;
                        $display("FAIL %s k=%0d mem_we got=%b exp=%b", name, k, mem_we,
                                 (kind == K_STORE));
                    end
                end
                if (k == wb_c) begin
                    checks++;
                    if (acc_bus !== rdata) begin
                        failures++;
                        $display("FAIL %s k=%0d acc_bus got=%h exp=%h", name, k, acc_bus, rdata);
                    end
                end
            end
            clear_inputs();
            if (k == 0) begin
                load_start  = (kind != K_STORE);
                store_start = (kind != K_LOAD);
                dmar        = addr;
                acc_out     = wdata;
            end
            if (stray_start && k == 1) begin
                load_start  = 1'b1;
                store_start = ($urandom_range(0, 1) == 1);
            end
            if (kind != K_BOTH && g >= 0 && g <= T - 1 && k == cg) mem_gnt = 1'b1;
            if (kind == K_LOAD && g >= 0 && g <= T - 1 && r >= 0 && r <= T && k == cg + r) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
            end
            if (stray_rv && k == idle_c) mem_rvalid = 1'b1;
        end
        m_addr  = exp_addr;
        m_wdata = exp_wdata;
    endtask

    task automatic test_reset_abort(input string name, input bit in_wait);
        logic [11:0] addr;
        addr = 12'($urandom) | 12'h001;
        @(negedge clk);
        clear_inputs();
        load_start = 1'b1;
        dmar       = addr;
        @(negedge clk);
        clear_inputs();
        if (in_wait) mem_gnt = 1'b1;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL %s pre_reset mem_req got=%b exp=1", name, mem_req);
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if (busy !== 1'b1 || mem_req !== !in_wait) begin
            failures++;
            $display("FAIL %s pre_reset busy/mem_req got=%b/%b exp=1/%b", name, busy,
                     mem_req, !in_wait);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, busy, acc_write_enable, done, error} !== 5'b0 || mem_addr !== 12'h000) begin
            failures++;
            $display("FAIL %s async_reset ctrl got=%b addr=%h exp=00000/000", name,
                     {mem_req, busy, acc_write_enable, done, error}, mem_addr);
        end
        @(negedge clk);
        reset_n    = 1'b1;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        m_addr     = 12'h000;
        m_wdata    = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            clear_inputs();
            checks++;
            if ({mem_req, busy, acc_write_enable, done, error} !== 5'b0) begin
                failures++;
                $display("FAIL %s late_rvalid k=%0d ctrl got=%b exp=00000", name, k,
                         {mem_req, busy, acc_write_enable, done, error});
            end
        end
    endtask

    task automatic test_directed();
        run_txn("store_basic", K_STORE, 12'h3A5, 8'hC7, 0, 0, 8'h00, 1'b0, 1'b0);
        run_txn("load_gnt2_rv1", K_LOAD, 12'h010, 8'h00, 2, 1, 8'h5E, 1'b0, 1'b0);
        run_txn("load_same_cycle", K_LOAD, 12'h222, 8'h00, 0, 0, 8'h81, 1'b0, 1'b0);
        run_txn("load_rv_timeout", K_LOAD, 12'h0F0, 8'h00, 0, 99, 8'h00, 1'b0, 1'b1);
        run_txn("store_after_to", K_STORE, 12'h7FF, 8'h3C, 1, 0, 8'h00, 1'b0, 1'b0);
        run_txn("both_starts", K_BOTH, 12'hABC, 8'h99, 0, 0, 8'h00, 1'b0, 1'b0);
        run_txn("stray_store", K_LOAD, 12'h123, 8'h00, 1, 2, 8'h4D, 1'b1, 1'b0);
    endtask

    task automatic test_boundaries();
        run_txn("store_gnt_last", K_STORE, 12'h555, 8'hA5, T - 1, 0, 8'h00, 1'b0, 1'b0);
        run_txn("store_gnt_to", K_STORE, 12'h666, 8'h5A, -1, 0, 8'h00, 1'b0, 1'b0);
        run_txn("load_rv_last", K_LOAD, 12'h777, 8'h00, 0, T, 8'hE1, 1'b0, 1'b0);
        run_txn("load_gnt_to", K_LOAD, 12'h888, 8'h00, -1, 0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int pick, kind, g, r;
            pick = int'($urandom_range(0, 9));
            kind = (pick == 0) ? K_BOTH : (pick < 5) ? K_STORE : K_LOAD;
            g = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            r = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 4));
            run_txn("random", kind, 12'($urandom), 8'($urandom), g, r, 8'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_boundaries();
        test_reset_abort("reset_in_wait", 1'b1);
        test_reset_abort("reset_in_req", 1'b0);
        run_txn("post_reset_store", K_STORE, 12'h0A0, 8'h11, 0, 0, 8'h00, 1'b0, 1'b0);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
